ittage_sram_port_arb: RTL and testbench
=======================================

ITTAGE_SRAM_PORT_ARB -- requirements
Module: ittage_sram_port_arb

Interface
- REQ-001 SHALL have parameter WR_STARVE_MAX, default 4: max consecutive read grants while a write is buffered.
- REQ-002 SHALL have port clk, input, 1: sole clock; all state on rising edge.
- REQ-003 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
- REQ-004 SHALL have port rd_req_valid, input, 1: read request.
- REQ-005 SHALL have port rd_req_ready, output, 1: read accepted this cycle.
- REQ-006 SHALL have port rd_req_addr, input, 7: read row.
- REQ-007 SHALL have port rd_resp_valid, output, 1: read data valid.
- REQ-008 SHALL have port rd_resp_data, output, 76: read data; held between responses.
- REQ-009 SHALL have port wr_req_valid, input, 1: write request.
- REQ-010 SHALL have port wr_req_ready, output, 1: write accepted.
- REQ-011 SHALL have ports wr_req_addr (input, 7), wr_req_mask (input, 76) and wr_req_data (input, 76): write row, bit mask and data.
- REQ-012 SHALL have port init_done, output, 1: array clear complete.
- REQ-013 SHALL have ports sram_addr (output, 7), sram_en (output, 1), sram_wmode (output, 1), sram_wmask (output, 76), sram_wdata (output, 76) and sram_rdata (input, 76): single-port 128x76 SRAM side, 1-cycle read latency.

Function
- REQ-014 SHALL run FSM INIT -> RUN; INIT is entered on reset, and RUN is held until the next reset.
- REQ-015 SHALL, in INIT, write one row per cycle: addr = clear counter 0..127, en=1, wmode=1, wmask=all ones, wdata=0; it SHALL enter RUN after row 127, for exactly 128 INIT cycles.
- REQ-016 SHALL hold rd_req_ready=0 and wr_req_ready=0 in INIT; init_done=1 exactly when in RUN.
- REQ-017 SHALL hold one write buffer entry (addr, mask, data, valid); wr_req_ready = init_done & ~wbuf_valid; it SHALL capture on valid&ready.
- REQ-018 SHALL, in RUN, select a write in a cycle when wbuf_valid and any of the following holds: ~rd_req_valid; starve_cnt==WR_STARVE_MAX; or rd_req_addr==wbuf_addr. Otherwise rd_req_valid selects a read.
- REQ-019 SHALL, on a write: drive en=1, wmode=1, and the buffered addr/mask/data; clear wbuf_valid at the edge; hold rd_req_ready=0.
- REQ-020 SHALL, on a read: drive rd_req_ready=1, en=1, wmode=0, addr=rd_req_addr, wmask=0, wdata=0.
- REQ-021 SHALL drive en=0 and addr/wmask/wdata/wmode all 0 when no access is selected.
- REQ-022 SHALL increment starve_cnt (saturating at WR_STARVE_MAX) when wbuf_valid and a read is granted; it SHALL clear starve_cnt on a write issue.
- REQ-023 SHALL assert rd_resp_valid exactly one cycle after a read grant, with rd_resp_data = sram_rdata in that cycle.
- REQ-024 SHALL capture the response into a hold register; while rd_resp_valid=0, rd_resp_data SHALL equal the last response (0 after reset).
- REQ-025 SHALL NOT refill the buffer on the cycle its write issues; the earliest next acceptance is the following cycle.
- REQ-026 SHALL sustain back-to-back reads at one per cycle when no write is buffered.

Reset
- REQ-027 SHALL, on rst_n low at any time, immediately clear the following: FSM to INIT, clear counter, wbuf_valid, starve_cnt, rd_resp_valid, hold register; the buffered write SHALL be discarded.
- REQ-028 SHALL hold sram_en=0 while rst_n=0; INIT SHALL begin on the first edge after deassertion.

Structure
- REQ-029 SHALL place ADDR_W=7, DATA_W=76, DEPTH=128 and the FSM state enum in package ittage_sram_pkg.
- REQ-030 SHALL be a single module with no sub-modules.

Verification
- REQ-031 SHALL check the reset clear: deassert rst_n -> 128 zero writes with full mask to rows 0..127, init_done rises on cycle 129, and later reads of any row return 0.
- REQ-032 SHALL check a write followed by a read: write row 5, data 0xABC, full mask; read row 5 two cycles later -> rd_resp_data=0xABC one cycle after the grant.
- REQ-033 SHALL check the starvation bound: continuous reads to row 1 with a write buffered to row 9 -> 4 reads granted, then the write issues on the 5th cycle.
- REQ-034 SHALL check the address hazard: write buffered to row 3, mask 0xF, data 0x5; read row 3 in the same cycle -> the write issues first, the read is granted the next cycle, and the response low nibble is 0x5.
- REQ-035 SHALL check the hold behaviour: read row 7 -> response; then idle for 10 cycles -> rd_resp_data is unchanged and rd_resp_valid=0.
- REQ-036 SHALL check reset mid-operation: rst_n low while a write is buffered -> write never issued, and the INIT sweep restarts from row 0.

Source files
------------

// File: rtl/ittage_sram_pkg.sv
// Shared widths, FSM state and write-buffer entry type for the ITTAGE SRAM port arbiter.
package ittage_sram_pkg;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 76;
  localparam int DEPTH  = 128;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] mask;
    logic [DATA_W-1:0] data;
  } wr_entry_t;

endpackage

// File: rtl/ittage_sram_port_arb.sv
// Arbitrates one read port and one buffered write port onto a single-port 128x76 SRAM,
// after clearing the whole array once following reset.
module ittage_sram_port_arb
  import ittage_sram_pkg::*;
#(
  parameter int WR_STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_req_valid,
  output logic              rd_req_ready,
  input  logic [ADDR_W-1:0] rd_req_addr,
  output logic              rd_resp_valid,
  output logic [DATA_W-1:0] rd_resp_data,
  input  logic              wr_req_valid,
  output logic              wr_req_ready,
  input  logic [ADDR_W-1:0] wr_req_addr,
  input  logic [DATA_W-1:0] wr_req_mask,
  input  logic [DATA_W-1:0] wr_req_data,
  output logic              init_done,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_en,
  output logic              sram_wmode,
  output logic [DATA_W-1:0] sram_wmask,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  localparam int                SC_W       = (WR_STARVE_MAX < 1) ? 1 : $clog2(WR_STARVE_MAX + 1);
  localparam logic [SC_W-1:0]   STARVE_LIM = SC_W'(WR_STARVE_MAX);
  localparam logic [ADDR_W-1:0] CLR_LAST   = ADDR_W'(DEPTH - 1);

  arb_state_e        r_state;
  logic [ADDR_W-1:0] r_clr_cnt;
  logic              r_wbuf_valid;
  wr_entry_t         r_wbuf;
  logic [SC_W-1:0]   r_starve_cnt;
  logic              r_rd_pend;
  logic [DATA_W-1:0] r_hold;

  logic w_run;
  logic w_init_act;
  logic w_wr_accept;
  logic w_wr_sel;
  logic w_rd_sel;

  // The clear sweep is gated by rst_n so the SRAM stays idle while reset is held.
  assign w_run       = (r_state == ST_RUN);
  assign w_init_act  = rst_n & (r_state == ST_INIT);
  assign w_wr_accept = wr_req_valid & wr_req_ready;

  assign w_wr_sel = w_run & r_wbuf_valid &
                    (~rd_req_valid | (r_starve_cnt == STARVE_LIM) | (rd_req_addr == r_wbuf.addr));
  assign w_rd_sel = w_run & rd_req_valid & ~w_wr_sel;

  assign init_done     = w_run;
  assign wr_req_ready  = w_run & ~r_wbuf_valid;
  assign rd_resp_valid = r_rd_pend;
  assign rd_resp_data  = r_rd_pend ? sram_rdata : r_hold;

  always_comb begin
    // NOTE: every output gets a default first, so no path through this block can infer a latch.
    rd_req_ready = 1'b0;
    sram_en      = 1'b0;
    sram_wmode   = 1'b0;
    sram_addr    = '0;
    sram_wmask   = '0;
    sram_wdata   = '0;
    if (w_init_act) begin
      sram_en    = 1'b1;
      sram_wmode = 1'b1;
      sram_addr  = r_clr_cnt;
      sram_wmask = '1;
    end else if (w_wr_sel) begin
      sram_en    = 1'b1;
      sram_wmode = 1'b1;
      sram_addr  = r_wbuf.addr;
      sram_wmask = r_wbuf.mask;
      sram_wdata = r_wbuf.data;
    end else if (w_rd_sel) begin
      rd_req_ready = 1'b1;
      sram_en      = 1'b1;
      sram_addr    = rd_req_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_INIT;
      r_clr_cnt    <= '0;
      r_wbuf_valid <= 1'b0;
      r_starve_cnt <= '0;
      r_rd_pend    <= 1'b0;
      r_hold       <= '0;
    end else begin
      // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
      if (r_state == ST_INIT) begin
        r_clr_cnt <= r_clr_cnt + ADDR_W'(1);
        if (r_clr_cnt == CLR_LAST) begin
          r_state <= ST_RUN;
        end
      end

      if (w_wr_sel) begin
        r_wbuf_valid <= 1'b0;
      end else if (w_wr_accept) begin
        r_wbuf_valid <= 1'b1;
      end

      if (w_wr_sel) begin
        r_starve_cnt <= '0;
      end else if (w_rd_sel && r_wbuf_valid && (r_starve_cnt != STARVE_LIM)) begin
        r_starve_cnt <= r_starve_cnt + SC_W'(1);
      end

      r_rd_pend <= w_rd_sel;
      if (r_rd_pend) begin
        r_hold <= sram_rdata;
      end
    end
  end

  // NOTE: the buffered payload is only ever read while r_wbuf_valid is set, so it carries no reset.
  always_ff @(posedge clk) begin
    if (w_wr_accept) begin
      r_wbuf <= '{addr: wr_req_addr, mask: wr_req_mask, data: wr_req_data};
    end
  end

endmodule

// File: tb/tb_ittage_sram_port_arb.sv
// Self-checking bench for ittage_sram_port_arb: behavioural SRAM, shadow memory and a
// response scoreboard, plus one task per scenario with inline comparisons.
module tb_ittage_sram_port_arb;
  import ittage_sram_pkg::*;

  localparam int STARVE = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              rd_req_valid;
  logic              rd_req_ready;
  logic [ADDR_W-1:0] rd_req_addr;
  logic              rd_resp_valid;
  logic [DATA_W-1:0] rd_resp_data;
  logic              wr_req_valid;
  logic              wr_req_ready;
  logic [ADDR_W-1:0] wr_req_addr;
  logic [DATA_W-1:0] wr_req_mask;
  logic [DATA_W-1:0] wr_req_data;
  logic              init_done;
  logic [ADDR_W-1:0] sram_addr;
  logic              sram_en;
  logic              sram_wmode;
  logic [DATA_W-1:0] sram_wmask;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [DATA_W-1:0] sram_mem [DEPTH];
  logic [DATA_W-1:0] shadow   [DEPTH];
  logic [DATA_W-1:0] exp_q    [$];
  logic [DATA_W-1:0] exp_v;

  logic              watch_en   = 1'b0;
  logic [ADDR_W-1:0] watch_addr = '0;
  logic [DATA_W-1:0] watch_data = '0;
  int                watch_hits = 0;

  ittage_sram_port_arb #(.WR_STARVE_MAX(STARVE)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rd_req_valid (rd_req_valid),
    .rd_req_ready (rd_req_ready),
    .rd_req_addr  (rd_req_addr),
    .rd_resp_valid(rd_resp_valid),
    .rd_resp_data (rd_resp_data),
    .wr_req_valid (wr_req_valid),
    .wr_req_ready (wr_req_ready),
    .wr_req_addr  (wr_req_addr),
    .wr_req_mask  (wr_req_mask),
    .wr_req_data  (wr_req_data),
    .init_done    (init_done),
    .sram_addr    (sram_addr),
    .sram_en      (sram_en),
    .sram_wmode   (sram_wmode),
    .sram_wmask   (sram_wmask),
    .sram_wdata   (sram_wdata),
    .sram_rdata   (sram_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] rand76();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[DATA_W-1:0];
  endfunction

  // Single-port SRAM, 1-cycle read latency; read data turns to noise on non-read cycles.
  always @(posedge clk) begin
    if (sram_en && sram_wmode) begin
      sram_mem[sram_addr] <= (sram_mem[sram_addr] & ~sram_wmask) | (sram_wdata & sram_wmask);
      sram_rdata <= rand76();
    end else if (sram_en) begin
      sram_rdata <= sram_mem[sram_addr];
    end else begin
      sram_rdata <= rand76();
    end
  end

  // Scoreboard: expected read data is taken from the shadow at grant time.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (rd_resp_valid) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL scoreboard_unexpected_resp: got data %h with no read outstanding", rd_resp_data);
        end else begin
          exp_v = exp_q.pop_front();
          if (rd_resp_data !== exp_v) begin
            tests_failed++;
            $display("FAIL scoreboard_resp_data: got %h expected %h", rd_resp_data, exp_v);
          end
        end
      end
      if (rd_req_valid && rd_req_ready) exp_q.push_back(shadow[rd_req_addr]);
      if (wr_req_valid && wr_req_ready)
        shadow[wr_req_addr] = (shadow[wr_req_addr] & ~wr_req_mask) | (wr_req_data & wr_req_mask);
      if (watch_en && init_done && sram_en && sram_wmode &&
          sram_addr == watch_addr && sram_wdata == watch_data) watch_hits++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rd_req_valid = 1'b0;
    rd_req_addr  = '0;
    wr_req_valid = 1'b0;
    wr_req_addr  = '0;
    wr_req_mask  = '0;
    wr_req_data  = '0;
  endtask

  // Drives one write for a single cycle; the buffer must be empty on entry.
  task automatic put_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] m,
                           input logic [DATA_W-1:0] d);
    wr_req_valid = 1'b1;
    wr_req_addr  = a;
    wr_req_mask  = m;
    wr_req_data  = d;
    @(negedge clk);
    tests_run++;
    if (wr_req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL put_write_ready row %0d: got %b expected 1", a, wr_req_ready);
    end
    step();
    wr_req_valid = 1'b0;
  endtask

  task automatic reset_and_sweep(input string tag);
    idle_inputs();
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (sram_en !== 1'b0 || rd_resp_valid !== 1'b0 || rd_resp_data !== '0 || init_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_in_reset: en=%b resp_valid=%b resp_data=%h done=%b expected 0 0 0 0",
               tag, sram_en, rd_resp_valid, rd_resp_data, init_done);
    end
    repeat (3) step();
    tests_run++;
    if (sram_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_held_reset_en: got %b expected 0", tag, sram_en);
    end
    foreach (shadow[i]) shadow[i] = '0;
    rst_n        = 1'b1;
    rd_req_valid = 1'b1;
    rd_req_addr  = 7'd3;
    wr_req_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      tests_run++;
      if (sram_en !== 1'b1 || sram_wmode !== 1'b1 || sram_addr !== ADDR_W'(i) ||
          sram_wmask !== {DATA_W{1'b1}} || sram_wdata !== '0 ||
          rd_req_ready !== 1'b0 || wr_req_ready !== 1'b0 || init_done !== 1'b0) begin
        tests_failed++;
        $display("FAIL %s_sweep cycle %0d: en=%b wmode=%b addr=%0d mask=%h data=%h rd_rdy=%b wr_rdy=%b done=%b; expected 1 1 %0d all-ones 0 0 0 0",
                 tag, i + 1, sram_en, sram_wmode, sram_addr, sram_wmask, sram_wdata,
                 rd_req_ready, wr_req_ready, init_done, i);
      end
      step();
    end
    idle_inputs();
    @(negedge clk);
    tests_run++;
    if (init_done !== 1'b1 || wr_req_ready !== 1'b1 || sram_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_init_done cycle 129: done=%b wr_rdy=%b en=%b expected 1 1 0",
               tag, init_done, wr_req_ready, sram_en);
    end
    step();
  endtask

  task automatic test_reset();
    reset_and_sweep("reset");
  endtask

  task automatic test_back_to_back(input string tag, input int first, input int n);
    logic [ADDR_W-1:0] a;
    rd_req_valid = 1'b1;
    for (int k = 0; k <= n; k++) begin
      if (k == n) rd_req_valid = 1'b0;
      a = ADDR_W'((first + k) % DEPTH);
      rd_req_addr = a;
      @(negedge clk);
      if (k < n) begin
        tests_run++;
        if (rd_req_ready !== 1'b1 || sram_en !== 1'b1 || sram_wmode !== 1'b0 || sram_addr !== a) begin
          tests_failed++;
          $display("FAIL %s_grant row %0d: rdy=%b en=%b wmode=%b addr=%0d expected 1 1 0 %0d",
                   tag, a, rd_req_ready, sram_en, sram_wmode, sram_addr, a);
        end
      end
      if (k > 0) begin
        tests_run++;
        if (rd_resp_valid !== 1'b1) begin
          tests_failed++;
          $display("FAIL %s_resp_valid cycle %0d: got %b expected 1", tag, k, rd_resp_valid);
        end
      end
      step();
    end
  endtask

  task automatic test_write_read();
    logic [DATA_W-1:0] d5;
    d5 = 76'hABC;
    put_write(7'd5, '1, d5);
    wr_req_valid = 1'b1;
    wr_req_addr  = 7'd6;
    wr_req_mask  = '1;
    wr_req_data  = 76'h123;
    @(negedge clk);
    tests_run++;
    if (sram_en !== 1'b1 || sram_wmode !== 1'b1 || sram_addr !== 7'd5 ||
        sram_wmask !== {DATA_W{1'b1}} || sram_wdata !== d5 || wr_req_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL wr_issue: en=%b wmode=%b addr=%0d mask=%h data=%h wr_rdy=%b expected 1 1 5 all-ones %h 0",
               sram_en, sram_wmode, sram_addr, sram_wmask, sram_wdata, wr_req_ready, d5);
    end
    step();
    rd_req_valid = 1'b1;
    rd_req_addr  = 7'd5;
    @(negedge clk);
    tests_run++;
    if (rd_req_ready !== 1'b1 || wr_req_ready !== 1'b1 || sram_wmode !== 1'b0 || sram_addr !== 7'd5) begin
      tests_failed++;
      $display("FAIL rd_after_wr_grant: rd_rdy=%b wr_rdy=%b wmode=%b addr=%0d expected 1 1 0 5",
               rd_req_ready, wr_req_ready, sram_wmode, sram_addr);
    end
    step();
    idle_inputs();
    @(negedge clk);
    tests_run++;
    if (rd_resp_valid !== 1'b1 || rd_resp_data !== d5 || sram_wmode !== 1'b1 || sram_addr !== 7'd6) begin
      tests_failed++;
      $display("FAIL rd_after_wr_resp: valid=%b data=%h wmode=%b addr=%0d expected 1 %h 1 6",
               rd_resp_valid, rd_resp_data, sram_wmode, sram_addr, d5);
    end
    step();
  endtask

  task automatic test_starvation();
    logic exp_rd;
    rd_req_valid = 1'b1;
    rd_req_addr  = 7'd1;
    wr_req_valid = 1'b1;
    wr_req_addr  = 7'd9;
    wr_req_mask  = '1;
    wr_req_data  = 76'h5A5_0123_4567_89AB_CDEF;
    @(negedge clk);
    tests_run++;
    if (rd_req_ready !== 1'b1 || wr_req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL starve_setup: rd_rdy=%b wr_rdy=%b expected 1 1", rd_req_ready, wr_req_ready);
    end
    step();
    wr_req_valid = 1'b0;
    for (int k = 1; k <= STARVE + 2; k++) begin
      exp_rd = (k != STARVE + 1);
      @(negedge clk);
      tests_run++;
      if (rd_req_ready !== exp_rd || sram_wmode !== !exp_rd ||
          (!exp_rd && sram_addr !== 7'd9)) begin
        tests_failed++;
        $display("FAIL starve_cycle %0d: rd_rdy=%b wmode=%b addr=%0d expected rd_rdy=%b wmode=%b",
                 k, rd_req_ready, sram_wmode, sram_addr, exp_rd, !exp_rd);
      end
      step();
    end
    idle_inputs();
    step();
  endtask

  task automatic test_hazard();
    logic [DATA_W-1:0] p, e;
    p = 76'hC3C_FEDC_BA98_7654_3210;
    put_write(7'd3, '1, p);
    step();
    put_write(7'd3, 76'hF, 76'h5);
    e = (p & ~76'hF) | 76'h5;
    rd_req_valid = 1'b1;
    rd_req_addr  = 7'd3;
    @(negedge clk);
    tests_run++;
    if (rd_req_ready !== 1'b0 || sram_wmode !== 1'b1 || sram_addr !== 7'd3 || sram_wmask !== 76'hF) begin
      tests_failed++;
      $display("FAIL hazard_write_first: rd_rdy=%b wmode=%b addr=%0d mask=%h expected 0 1 3 f",
               rd_req_ready, sram_wmode, sram_addr, sram_wmask);
    end
    step();
    @(negedge clk);
    tests_run++;
    if (rd_req_ready !== 1'b1 || sram_wmode !== 1'b0 || sram_addr !== 7'd3) begin
      tests_failed++;
      $display("FAIL hazard_read_next: rd_rdy=%b wmode=%b addr=%0d expected 1 0 3",
               rd_req_ready, sram_wmode, sram_addr);
    end
    step();
    idle_inputs();
    @(negedge clk);
    tests_run++;
    if (rd_resp_valid !== 1'b1 || rd_resp_data !== e) begin
      tests_failed++;
      $display("FAIL hazard_resp: valid=%b data=%h expected 1 %h", rd_resp_valid, rd_resp_data, e);
    end
    step();
  endtask

  task automatic test_hold();
    logic [DATA_W-1:0] q;
    q = 76'h123_4567_89AB_CDEF_0F0F;
    put_write(7'd7, '1, q);
    step();
    rd_req_valid = 1'b1;
    rd_req_addr  = 7'd7;
    step();
    idle_inputs();
    @(negedge clk);
    tests_run++;
    if (rd_resp_valid !== 1'b1 || rd_resp_data !== q) begin
      tests_failed++;
      $display("FAIL hold_first_resp: valid=%b data=%h expected 1 %h", rd_resp_valid, rd_resp_data, q);
    end
    step();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      tests_run++;
      if (rd_resp_valid !== 1'b0 || rd_resp_data !== q || sram_en !== 1'b0 || sram_wmode !== 1'b0 ||
          sram_addr !== '0 || sram_wmask !== '0 || sram_wdata !== '0) begin
        tests_failed++;
        $display("FAIL hold_idle cycle %0d: valid=%b data=%h en=%b wmode=%b addr=%0d mask=%h wdata=%h expected 0 %h 0 0 0 0 0",
                 k, rd_resp_valid, rd_resp_data, sram_en, sram_wmode, sram_addr, sram_wmask, sram_wdata, q);
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    watch_addr = 7'd42;
    watch_data = 76'hDEA_DBEE_F012_3456_789A;
    watch_hits = 0;
    watch_en   = 1'b1;
    put_write(watch_addr, '1, watch_data);
    reset_and_sweep("midreset");
    test_back_to_back("midreset_read", 42, 1);
    repeat (3) step();
    watch_en = 1'b0;
    tests_run++;
    if (watch_hits !== 0) begin
      tests_failed++;
      $display("FAIL midreset_discard: discarded write issued %0d times, expected 0", watch_hits);
    end
  endtask

  initial begin
    idle_inputs();
    step();
    test_reset();
    test_back_to_back("init_reads", 0, DEPTH);
    test_write_read();
    test_starvation();
    test_hazard();
    test_hold();
    for (int r = 10; r < 14; r++) begin
      put_write(ADDR_W'(r), rand76(), rand76());
      step();
    end
    test_back_to_back("b2b", 8, 8);
    test_reset_mid();
    for (int k = 0; k < 10 && exp_q.size() != 0; k++) step();
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL drain: %0d responses outstanding, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
